// File: rtl/wb_trace_streamer_pkg.sv
// Shared trace record layout for the writeback trace streamer.
// Record packing (68 bits): pc [67:36], rd [35:32], data [31:0].
package wb_trace_streamer_pkg;

   localparam int TRACE_REC_W = 68;
   localparam logic [31:0] TRACE_PC_OFS = 32'd8;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  rd;
      logic [31:0] data;
   } trace_rec_t;

   // The writeback stage carries PC+8; the record holds the instruction PC.
   function automatic trace_rec_t make_rec(input logic [31:0] pc_plus8,
                                           input logic [3:0]  rd,
                                           input logic [31:0] data);
      trace_rec_t r;
      r.pc   = pc_plus8 - TRACE_PC_OFS;
      r.rd   = rd;
      r.data = data;
      return r;
   endfunction

endpackage

// File: rtl/wb_trace_streamer_trace_fifo.sv
// Dual-push, single-pop circular buffer. din0 is stored ahead of din1
// when two entries are pushed in the same cycle.
module trace_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 68
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [1:0]                 push_cnt,
   input  logic [W-1:0]               din0,
   input  logic [W-1:0]               din1,
   input  logic                       pop,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push_cnt);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + (AW+1)'(push_cnt) - (AW+1)'(pop);
      end
   end

   // Storage is data only; validity is tracked solely by count.
   always_ff @(posedge clk) begin
      if (push_cnt != 2'd0)
         mem[wr_ptr] <= din0;
      if (push_cnt == 2'd2)
         mem[wr_ptr + AW'(1)] <= din1;
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/wb_trace_streamer.sv
// Captures register-file writebacks (both write ports) and streams them out as
// PC-tagged records; events that do not fit are dropped atomically and counted.
module wb_trace_streamer
   import wb_trace_streamer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       RegWriteW,
   input  logic [3:0]       wa3,
   input  logic [31:0]      wd3,
   input  logic [3:0]       wa3_2,
   input  logic [31:0]      wd3_2,
   input  logic [31:0]      PCPlus8W,
   output logic             trace_valid,
   input  logic             trace_ready,
   output logic [31:0]      trace_pc,
   output logic [3:0]       trace_reg,
   output logic [31:0]      trace_data,
   output logic [CNT_W-1:0] drop_count,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);

   logic             ev0;
   logic             ev1;
   logic [1:0]       n_ev;
   logic [AW:0]      count;
   logic [AW:0]      free;
   logic             fits;
   logic [1:0]       push_cnt;
   trace_rec_t       rec0;
   trace_rec_t       rec1;
   trace_rec_t       din0;
   trace_rec_t       head;
   logic             pop;
   logic [CNT_W:0]   drop_sum;

   // Free space uses the count at the start of the cycle: a same-cycle pop
   // is deliberately not credited, so the fit decision never depends on ready.
   always_comb begin
      ev0      = enable & RegWriteW[0];
      ev1      = enable & RegWriteW[1];
      n_ev     = {1'b0, ev0} + {1'b0, ev1};
      free     = (AW+1)'(DEPTH) - count;
      fits     = ((AW+1)'(n_ev) <= free);
      push_cnt = fits ? n_ev : 2'd0;
      rec0     = make_rec(PCPlus8W, wa3, wd3);
      rec1     = make_rec(PCPlus8W, wa3_2, wd3_2);
      din0     = ev0 ? rec0 : rec1;
      drop_sum = {1'b0, drop_count} + (CNT_W+1)'(n_ev);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drop_count <= '0;
         overflow   <= 1'b0;
      end else if ((n_ev != 2'd0) && !fits) begin
         overflow   <= 1'b1;
         drop_count <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end
   end

   trace_fifo #(
      .DEPTH (DEPTH),
      .W     (TRACE_REC_W)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_cnt (push_cnt),
      .din0     (din0),
      .din1     (rec1),
      .pop      (pop),
      .dout     (head),
      .count    (count)
   );

   // Outputs read zero whenever nothing is presented, including during reset.
   assign trace_valid = (count != '0);
   assign pop         = trace_valid & trace_ready;
   assign trace_pc    = trace_valid ? head.pc   : 32'd0;
   assign trace_reg   = trace_valid ? head.rd   : 4'd0;
   assign trace_data  = trace_valid ? head.data : 32'd0;

endmodule

// File: tb/tb_wb_trace_streamer.sv
// Directed bench for wb_trace_streamer: a DEPTH=8/CNT_W=16 instance plus a
// CNT_W=2 instance sharing the same stimulus for drop-counter saturation.
module tb_wb_trace_streamer;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [1:0]  RegWriteW;
   logic [3:0]  wa3;
   logic [31:0] wd3;
   logic [3:0]  wa3_2;
   logic [31:0] wd3_2;
   logic [31:0] PCPlus8W;
   logic        trace_ready;

   logic        trace_valid;
   logic [31:0] trace_pc;
   logic [3:0]  trace_reg;
   logic [31:0] trace_data;
   logic [15:0] drop_count;
   logic        overflow;

   logic        s_valid;
   logic [31:0] s_pc;
   logic [3:0]  s_reg;
   logic [31:0] s_data;
   logic [1:0]  s_drop;
   logic        s_overflow;

   int checks   = 0;
   int failures = 0;

   wb_trace_streamer #(.DEPTH(8), .CNT_W(16)) dut (
      .clk (clk), .reset (reset), .enable (enable), .RegWriteW (RegWriteW),
      .wa3 (wa3), .wd3 (wd3), .wa3_2 (wa3_2), .wd3_2 (wd3_2), .PCPlus8W (PCPlus8W),
      .trace_valid (trace_valid), .trace_ready (trace_ready), .trace_pc (trace_pc),
      .trace_reg (trace_reg), .trace_data (trace_data), .drop_count (drop_count),
      .overflow (overflow)
   );

   wb_trace_streamer #(.DEPTH(8), .CNT_W(2)) dut_sat (
      .clk (clk), .reset (reset), .enable (enable), .RegWriteW (RegWriteW),
      .wa3 (wa3), .wd3 (wd3), .wa3_2 (wa3_2), .wd3_2 (wd3_2), .PCPlus8W (PCPlus8W),
      .trace_valid (s_valid), .trace_ready (trace_ready), .trace_pc (s_pc),
      .trace_reg (s_reg), .trace_data (s_data), .drop_count (s_drop),
      .overflow (s_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      RegWriteW = 2'b00;
   endtask

   task automatic ev1(input logic [3:0] r, input logic [31:0] d, input logic [31:0] pc8);
      RegWriteW = 2'b01; wa3 = r; wd3 = d; PCPlus8W = pc8;
   endtask

   task automatic ev2(input logic [3:0] r0, input logic [31:0] d0,
                      input logic [3:0] r1, input logic [31:0] d1, input logic [31:0] pc8);
      RegWriteW = 2'b11; wa3 = r0; wd3 = d0; wa3_2 = r1; wd3_2 = d1; PCPlus8W = pc8;
   endtask

   initial begin
      reset = 1'b0; enable = 1'b1; RegWriteW = 2'b00; wa3 = '0; wd3 = '0;
      wa3_2 = '0; wd3_2 = '0; PCPlus8W = '0; trace_ready = 1'b0;
      step(); step();
      chk("rst_valid", 32'(trace_valid), 32'd0);
      chk("rst_drop", 32'(drop_count), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_pc", trace_pc, 32'd0);
      reset = 1'b1;

      // Single write, latency one cycle.
      trace_ready = 1'b1;
      ev1(4'd3, 32'h1234, 32'h108);
      step(); idle();
      chk("single_valid", 32'(trace_valid), 32'd1);
      chk("single_pc", trace_pc, 32'h100);
      chk("single_reg", 32'(trace_reg), 32'd3);
      chk("single_data", trace_data, 32'h1234);
      step();
      chk("single_empty", 32'(trace_valid), 32'd0);

      // Dual write: port 1 first, shared pc.
      ev2(4'd4, 32'hAAAA, 4'd5, 32'hBBBB, 32'h208);
      step(); idle();
      chk("dual0_reg", 32'(trace_reg), 32'd4);
      chk("dual0_data", trace_data, 32'hAAAA);
      chk("dual0_pc", trace_pc, 32'h200);
      step();
      chk("dual1_reg", 32'(trace_reg), 32'd5);
      chk("dual1_data", trace_data, 32'hBBBB);
      chk("dual1_pc", trace_pc, 32'h200);
      step();
      chk("dual_empty", 32'(trace_valid), 32'd0);

      // Port 2 alone.
      RegWriteW = 2'b10; wa3_2 = 4'd9; wd3_2 = 32'h77; PCPlus8W = 32'h8;
      step(); idle();
      chk("p2only_reg", 32'(trace_reg), 32'd9);
      chk("p2only_pc", trace_pc, 32'h0);
      step();

      // Backpressure.
      trace_ready = 1'b0;
      ev1(4'd1, 32'h11, 32'h308);
      step();
      ev2(4'd2, 32'h22, 4'd3, 32'h33, 32'h408);
      step(); idle();
      chk("bp_hold_data", trace_data, 32'h11);
      step();
      chk("bp_hold_data2", trace_data, 32'h11);
      chk("bp_hold_pc", trace_pc, 32'h300);
      trace_ready = 1'b1;
      step();
      chk("bp_out1_data", trace_data, 32'h22);
      chk("bp_out1_pc", trace_pc, 32'h400);
      step();
      chk("bp_out2_data", trace_data, 32'h33);
      step();
      chk("bp_empty", 32'(trace_valid), 32'd0);

      // Overflow: 7 entries, dual event dropped, then a single fits.
      trace_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         ev1(4'(i), 32'h100 + 32'(i), 32'h1008 + 32'(8 * i));
         step();
      end
      ev2(4'hE, 32'hDEAD, 4'hF, 32'hBEEF, 32'h2008);
      step(); idle();
      chk("ovf_drop", 32'(drop_count), 32'd2);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("sat_drop2", 32'(s_drop), 32'd2);
      ev1(4'd7, 32'h107, 32'h1040);
      step(); idle();
      chk("ovf_fit_drop", 32'(drop_count), 32'd2);
      ev2(4'hE, 32'hDEAD, 4'hF, 32'hBEEF, 32'h2008);
      step(); idle();
      chk("full_dual_drop", 32'(drop_count), 32'd4);
      chk("sat_drop3", 32'(s_drop), 32'd3);

      // Full with ready: single event dropped, pop proceeds.
      trace_ready = 1'b1;
      ev1(4'hA, 32'h999, 32'h3008);
      step(); idle();
      chk("full_pop_drop", 32'(drop_count), 32'd5);
      chk("sat_stuck", 32'(s_drop), 32'd3);
      for (int i = 1; i < 8; i++) begin
         chk($sformatf("drain%0d_data", i), trace_data, 32'h100 + 32'(i));
         chk($sformatf("drain%0d_pc", i), trace_pc, 32'h1000 + 32'(8 * i));
         step();
      end
      chk("drain_empty", 32'(trace_valid), 32'd0);

      // Enable low: nothing captured, nothing counted.
      enable = 1'b0;
      ev2(4'd1, 32'h1, 4'd2, 32'h2, 32'h8);
      step(); idle();
      enable = 1'b1;
      chk("en_off_valid", 32'(trace_valid), 32'd0);
      chk("en_off_drop", 32'(drop_count), 32'd5);

      // Full-rate streaming across pointer wrap.
      for (int i = 0; i < 20; i++) begin
         ev1(4'(i), 32'h500 + 32'(i), 32'h5008);
         step();
         chk($sformatf("stream%0d_data", i), trace_data, 32'h500 + 32'(i));
      end
      idle();
      step();
      chk("stream_empty", 32'(trace_valid), 32'd0);
      chk("stream_nodrop", 32'(drop_count), 32'd5);

      // Async reset with 5 buffered records.
      trace_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ev1(4'(i), 32'h600 + 32'(i), 32'h6008);
         step();
      end
      idle();
      chk("pre_rst_valid", 32'(trace_valid), 32'd1);
      reset = 1'b0;
      #2;
      chk("arst_valid", 32'(trace_valid), 32'd0);
      chk("arst_drop", 32'(drop_count), 32'd0);
      chk("arst_ovf", 32'(overflow), 32'd0);
      chk("arst_data", trace_data, 32'd0);
      chk("arst_sat_drop", 32'(s_drop), 32'd0);
      reset = 1'b1;
      ev1(4'd6, 32'h700, 32'h7008);
      step(); idle();
      chk("post_rst_valid", 32'(trace_valid), 32'd1);
      chk("post_rst_data", trace_data, 32'h700);
      chk("post_rst_pc", trace_pc, 32'h7000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
